// File: rtl/multi_sampler_pkg.sv
// Shared types and size helpers for the multi-channel ADC capture buffer.
package multi_sampler_pkg;

    localparam int unsigned STATE_SIZE = 3;

    typedef enum logic [STATE_SIZE-1:0] {
        StIdle    = 3'd0,
        StArmed   = 3'd1,
        StCapture = 3'd2,
        StRead    = 3'd3,
        StHold    = 3'd4
    } state_e;

    // A single channel still needs a 1-bit channel index.
    function automatic int unsigned calc_ch_size(input int unsigned num_channels);
        return (num_channels > 1) ? $clog2(num_channels) : 1;
    endfunction

    function automatic int unsigned calc_addr_size(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/multi_sampler_ram.sv
// Single-port synchronous sample store, one full multi-channel word per address.
module sampler_ram #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned ADDR_SIZE = 10
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_we,
    input  logic                 i_re,
    input  logic [ADDR_SIZE-1:0] i_addr,
    input  logic [WIDTH-1:0]     i_wdata,
    output logic [WIDTH-1:0]     o_rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge i_clock) begin
        if (i_we) begin
            mem[i_addr] <= i_wdata;
        end
    end

    // Read register holds its value between reads so HOLD can keep presenting it.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rdata_q <= '0;
        end else if (i_re) begin
            rdata_q <= mem[i_addr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/multi_sampler.sv
// Gated, decimated multi-channel ADC capture with word-by-word paced readout.
module multi_sampler
    import multi_sampler_pkg::*;
#(
    parameter int unsigned DATA_SIZE    = 8,
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned ADDR_SIZE    = calc_addr_size(DEPTH),
    parameter int unsigned CH_SIZE      = calc_ch_size(NUM_CHANNELS),
    parameter int unsigned DECIM_SIZE   = 8
) (
    input  logic                              i_clock,
    input  logic                              i_reset_n,
    input  logic                              i_adc_init,
    input  logic                              i_arm,
    input  logic                              i_continuous,
    input  logic                              i_gate,
    input  logic [DECIM_SIZE-1:0]             i_decim,
    input  logic [NUM_CHANNELS*DATA_SIZE-1:0] i_data,
    input  logic                              i_next,
    output logic [DATA_SIZE-1:0]              o_data,
    output logic [CH_SIZE-1:0]                o_channel,
    output logic [ADDR_SIZE-1:0]              o_index,
    output logic                              o_valid,
    output logic                              o_idle,
    output logic                              o_done
);

    localparam int unsigned WORD_SIZE = NUM_CHANNELS * DATA_SIZE;
    localparam logic [ADDR_SIZE-1:0] LAST_IDX = ADDR_SIZE'(DEPTH - 1);
    localparam logic [CH_SIZE-1:0] LAST_CH = CH_SIZE'(NUM_CHANNELS - 1);

    state_e                 state_q, state_d;
    logic [ADDR_SIZE-1:0]   wr_idx_q, wr_idx_d;
    logic [ADDR_SIZE-1:0]   rd_idx_q, rd_idx_d;
    logic [CH_SIZE-1:0]     ch_q, ch_d;
    logic [DECIM_SIZE-1:0]  decim_cnt_q, decim_cnt_d;
    logic [DECIM_SIZE-1:0]  decim_lat_q, decim_lat_d;
    logic                   cont_q, cont_d;
    logic                   done_q, done_d;
    logic                   arm_q, next_q;
    logic                   arm_edge, next_edge;
    logic                   ram_we, ram_re;
    logic [ADDR_SIZE-1:0]   ram_addr;
    logic [WORD_SIZE-1:0]   ram_rdata;

    assign arm_edge  = i_arm & ~arm_q;
    assign next_edge = i_next & ~next_q;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= StIdle;
        end else if (!i_adc_init) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            ch_q        <= '0;
            decim_cnt_q <= '0;
            decim_lat_q <= '0;
            cont_q      <= 1'b0;
            done_q      <= 1'b0;
            arm_q       <= 1'b0;
            next_q      <= 1'b0;
        end else if (!i_adc_init) begin
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            ch_q        <= '0;
            decim_cnt_q <= '0;
            decim_lat_q <= '0;
            cont_q      <= 1'b0;
            done_q      <= 1'b0;
            arm_q       <= 1'b0;
            next_q      <= 1'b0;
        end else begin
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            ch_q        <= ch_d;
            decim_cnt_q <= decim_cnt_d;
            decim_lat_q <= decim_lat_d;
            cont_q      <= cont_d;
            done_q      <= done_d;
            arm_q       <= i_arm;
            next_q      <= i_next;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        ch_d        = ch_q;
        decim_cnt_d = decim_cnt_q;
        decim_lat_d = decim_lat_q;
        cont_d      = cont_q;
        done_d      = 1'b0;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        unique case (state_q)
            StIdle, StArmed: begin
                if (arm_edge) begin
                    decim_lat_d = i_decim;
                    cont_d      = i_continuous;
                    wr_idx_d    = '0;
                    decim_cnt_d = '0;
                    state_d     = StCapture;
                end
            end
            StCapture: begin
                if (i_gate) begin
                    decim_cnt_d = (decim_cnt_q == decim_lat_q) ? '0
                                                               : decim_cnt_q + DECIM_SIZE'(1);
                    if (decim_cnt_q == '0) begin
                        ram_we   = i_adc_init;
                        wr_idx_d = wr_idx_q + ADDR_SIZE'(1);
                        if (wr_idx_q == LAST_IDX) begin
                            wr_idx_d = '0;
                            rd_idx_d = '0;
                            ch_d     = '0;
                            state_d  = StRead;
                        end
                    end
                end
            end
            StRead: begin
                ram_re  = 1'b1;
                state_d = StHold;
            end
            StHold: begin
                if (next_edge) begin
                    if (ch_q == LAST_CH) begin
                        ch_d = '0;
                        // Readout stops at the last word rather than wrapping.
                        if (rd_idx_q == LAST_IDX) begin
                            done_d  = 1'b1;
                            state_d = cont_q ? StArmed : StIdle;
                        end else begin
                            rd_idx_d = rd_idx_q + ADDR_SIZE'(1);
                            state_d  = StRead;
                        end
                    end else begin
                        ch_d    = ch_q + CH_SIZE'(1);
                        state_d = StRead;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        o_valid   = 1'b0;
        o_idle    = (state_q == StIdle);
        o_done    = done_q;
        o_data    = '0;
        o_channel = '0;
        o_index   = '0;
        if (state_q == StHold) begin
            o_valid   = 1'b1;
            o_data    = ram_rdata[ch_q*DATA_SIZE +: DATA_SIZE];
            o_channel = ch_q;
            o_index   = rd_idx_q;
        end
    end

    assign ram_addr = (state_q == StCapture) ? wr_idx_q : rd_idx_q;

    sampler_ram #(
        .WIDTH     (WORD_SIZE),
        .DEPTH     (DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_ram (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_we      (ram_we),
        .i_re      (ram_re),
        .i_addr    (ram_addr),
        .i_wdata   (i_data),
        .o_rdata   (ram_rdata)
    );

endmodule

// File: tb/tb_multi_sampler.sv
// Directed bench for multi_sampler with DEPTH=4, NUM_CHANNELS=2, DATA_SIZE=8.
module tb_multi_sampler;

    logic        i_clock = 1'b0;
    logic        i_reset_n;
    logic        i_adc_init;
    logic        i_arm;
    logic        i_continuous;
    logic        i_gate;
    logic [7:0]  i_decim;
    logic [15:0] i_data;
    logic        i_next;
    logic [7:0]  o_data;
    logic [0:0]  o_channel;
    logic [1:0]  o_index;
    logic        o_valid;
    logic        o_idle;
    logic        o_done;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp0 [4];
    logic [7:0] exp1 [4];

    always #5 i_clock = ~i_clock;

    multi_sampler #(
        .DATA_SIZE    (8),
        .NUM_CHANNELS (2),
        .DEPTH        (4),
        .DECIM_SIZE   (8)
    ) dut (
        .i_clock      (i_clock),
        .i_reset_n    (i_reset_n),
        .i_adc_init   (i_adc_init),
        .i_arm        (i_arm),
        .i_continuous (i_continuous),
        .i_gate       (i_gate),
        .i_decim      (i_decim),
        .i_data       (i_data),
        .i_next       (i_next),
        .o_data       (o_data),
        .o_channel    (o_channel),
        .o_index      (o_index),
        .o_valid      (o_valid),
        .o_idle       (o_idle),
        .o_done       (o_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic arm();
        i_arm = 1'b1;
        tick();
        i_arm = 1'b0;
    endtask

    // Starts in HOLD on word (0,0); walks all 8 words against exp0/exp1.
    task automatic readout(input logic exp_idle);
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < 2; c++) begin
                check("valid", 32'(o_valid), 1);
                check("index", 32'(o_index), i);
                check("channel", 32'(o_channel), c);
                check("data", 32'(o_data), (c == 0) ? 32'(exp0[i]) : 32'(exp1[i]));
                i_next = 1'b1;
                tick();
                if (!(i == 3 && c == 1)) begin
                    check("gap_valid", 32'(o_valid), 0);
                    i_next = 1'b0;
                    tick();
                end
            end
        end
        check("done_set", 32'(o_done), 1);
        check("idle_after", 32'(o_idle), 32'(exp_idle));
        check("valid_after", 32'(o_valid), 0);
        i_next = 1'b0;
        tick();
        check("done_pulse", 32'(o_done), 0);
    endtask

    initial begin
        i_reset_n    = 1'b1;
        i_adc_init   = 1'b1;
        i_arm        = 1'b0;
        i_continuous = 1'b0;
        i_gate       = 1'b1;
        i_decim      = 8'd0;
        i_data       = 16'd0;
        i_next       = 1'b0;
        #1 i_reset_n = 1'b0;
        #1;
        check("rst_idle", 32'(o_idle), 1);
        check("rst_valid", 32'(o_valid), 0);
        check("rst_data", 32'(o_data), 0);
        check("rst_done", 32'(o_done), 0);
        tick();
        i_reset_n = 1'b1;
        tick();

        // Basic capture/readout: ch0=10+i, ch1=20+i.
        arm();
        check("armed_capture", 32'(o_idle), 0);
        for (int i = 0; i < 4; i++) begin
            i_data = {8'(20 + i), 8'(10 + i)};
            tick();
        end
        check("read_latency", 32'(o_valid), 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            exp0[i] = 8'(10 + i);
            exp1[i] = 8'(20 + i);
        end
        readout(1'b1);

        // Gating: only even cycles are gated in.
        arm();
        for (int c = 0; c < 7; c++) begin
            i_gate = (c % 2 == 0);
            i_data = {8'(c + 100), 8'(c)};
            tick();
        end
        i_gate = 1'b1;
        check("gate_read", 32'(o_valid), 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            exp0[i] = 8'(2 * i);
            exp1[i] = 8'(2 * i + 100);
        end
        readout(1'b1);

        // Decimation by 3; later decim change must not matter.
        i_decim = 8'd2;
        arm();
        i_decim = 8'd0;
        for (int c = 0; c < 10; c++) begin
            i_data = {8'(c + 50), 8'(c)};
            tick();
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            exp0[i] = 8'(3 * i);
            exp1[i] = 8'(3 * i + 50);
        end
        readout(1'b1);

        // Handshake: edges in CAPTURE/READ dropped, held i_next advances once.
        arm();
        for (int c = 0; c < 4; c++) begin
            i_data = {8'(c + 30), 8'(c + 40)};
            i_next = (c == 1);
            tick();
        end
        i_next = 1'b1;
        tick();
        check("hs_first_valid", 32'(o_valid), 1);
        check("hs_first_ch", 32'(o_channel), 0);
        check("hs_first_data", 32'(o_data), 40);
        repeat (5) tick();
        check("hs_no_queue_ch", 32'(o_channel), 0);
        i_next = 1'b0;
        tick();
        i_next = 1'b1;
        repeat (10) tick();
        check("hs_one_adv_valid", 32'(o_valid), 1);
        check("hs_one_adv_idx", 32'(o_index), 0);
        check("hs_one_adv_ch", 32'(o_channel), 1);
        check("hs_one_adv_data", 32'(o_data), 30);
        i_next = 1'b0;
        tick();
        check("hs_hold_ch", 32'(o_channel), 1);
        i_adc_init = 1'b0;
        tick();
        check("abort_read_idle", 32'(o_idle), 1);
        check("abort_read_valid", 32'(o_valid), 0);
        i_adc_init = 1'b1;
        tick();

        // Continuous: ends in ARMED, second arm recaptures.
        i_continuous = 1'b1;
        arm();
        for (int i = 0; i < 4; i++) begin
            i_data = {8'(70 + i), 8'(60 + i)};
            tick();
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            exp0[i] = 8'(60 + i);
            exp1[i] = 8'(70 + i);
        end
        readout(1'b0);
        i_continuous = 1'b0;
        arm();
        check("rearm_capture", 32'(o_idle), 0);
        for (int i = 0; i < 4; i++) begin
            i_data = {8'(90 + i), 8'(80 + i)};
            tick();
        end
        tick();
        check("recap_data0", 32'(o_data), 80);
        i_next = 1'b1;
        tick();
        i_next = 1'b0;
        tick();
        check("recap_ch1", 32'(o_channel), 1);
        check("recap_data1", 32'(o_data), 90);

        // Asynchronous reset mid-HOLD clears outputs without a clock edge.
        #1 i_reset_n = 1'b0;
        #1;
        check("async_valid", 32'(o_valid), 0);
        check("async_data", 32'(o_data), 0);
        check("async_ch", 32'(o_channel), 0);
        check("async_idle", 32'(o_idle), 1);
        tick();
        i_reset_n = 1'b1;
        tick();

        // Arm edge coincident with adc_init low stays IDLE.
        i_arm      = 1'b1;
        i_adc_init = 1'b0;
        tick();
        check("arm_vs_init", 32'(o_idle), 1);
        i_arm      = 1'b0;
        i_adc_init = 1'b1;
        tick();
        check("arm_vs_init_after", 32'(o_idle), 1);

        // adc_init low mid-capture aborts to IDLE.
        arm();
        tick();
        tick();
        check("midcap_busy", 32'(o_idle), 0);
        i_adc_init = 1'b0;
        tick();
        check("midcap_abort_idle", 32'(o_idle), 1);
        check("midcap_abort_valid", 32'(o_valid), 0);
        i_adc_init = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
